// File: rtl/sat_bin_loader.sv
// Loads one bin (clauses, var states, lvl states) into sat_engine, starts it, captures the verdict.
// Latency: clause writes trail each accepted beat by 1 cycle; done_o 1 cycle after done_core_i seen in RUN.
// Backpressure: clause_ready_o high only while clause rows are outstanding; start_load_i dropped while busy.
module sat_bin_loader #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_load_i,
    input  logic [WIDTH_LVL-1:0]                   cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                   load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i,
    input  logic                                   clause_valid_i,
    output logic                                   clause_ready_o,
    input  logic [2*NUM_VARS-1:0]                  clause_data_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   result_sat_o,
    output logic                                   result_unsat_o,
    output logic [WIDTH_LVL-1:0]                   result_bkt_lvl_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   result_vars_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   result_lvl_states_o,
    output logic [31:0]                            run_cycles_o,
    output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
    output logic [2*NUM_VARS-1:0]                  clause_o,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    output logic                                   start_core_o,
    output logic                                   base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                   cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                   load_lvl_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    input  logic                                   done_core_i,
    input  logic                                   sat_i,
    input  logic                                   unsat_i,
    input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   eng_vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   eng_lvl_states_i
);
    localparam int IW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLAUSES - 1);

    // Each state names the phase whose engine strobe is currently visible on the outputs;
    // LOAD_C spends one extra cycle (ready low) while the last clause write drains.
    typedef enum logic [2:0] {
        IDLE, LOAD_C, WR_VS, WR_LS, START, RUN, CAPTURE
    } state_t;

    state_t                                 state;
    logic [IW-1:0]                          idx;
    logic [31:0]                            run_cnt;
    logic [31:0]                            run_cnt_inc;
    logic [WIDTH_LVL-1:0]                   cur_bin_q;
    logic [WIDTH_LVL-1:0]                   load_lvl_q;
    logic [WIDTH_LVL-1:0]                   base_lvl_q;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_q;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_q;

    // Profiling counter saturates rather than wrapping.
    assign run_cnt_inc = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;

    // Sequencer: state, snapshots, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            idx                  <= '0;
            run_cnt              <= '0;
            cur_bin_q            <= '0;
            load_lvl_q           <= '0;
            base_lvl_q           <= '0;
            vs_q                 <= '0;
            ls_q                 <= '0;
            clause_ready_o       <= 1'b0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            result_sat_o         <= 1'b0;
            result_unsat_o       <= 1'b0;
            result_bkt_lvl_o     <= '0;
            result_vars_states_o <= '0;
            result_lvl_states_o  <= '0;
            run_cycles_o         <= '0;
            wr_carray_o          <= '0;
            clause_o             <= '0;
            wr_var_states_o      <= '0;
            vars_states_o        <= '0;
            wr_lvl_states_o      <= '0;
            lvl_states_o         <= '0;
            start_core_o         <= 1'b0;
            base_lvl_en_o        <= 1'b0;
            cur_bin_num_o        <= '0;
            load_lvl_o           <= '0;
            base_lvl_o           <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wr_carray_o     <= '0;
            wr_var_states_o <= '0;
            wr_lvl_states_o <= '0;
            start_core_o    <= 1'b0;
            base_lvl_en_o   <= 1'b0;
            done_o          <= 1'b0;

            case (state)
                IDLE, CAPTURE: begin
                    state <= IDLE;
                    if (start_load_i) begin
                        cur_bin_q      <= cur_bin_num_i;
                        load_lvl_q     <= load_lvl_i;
                        base_lvl_q     <= base_lvl_i;
                        vs_q           <= vars_states_i;
                        ls_q           <= lvl_states_i;
                        idx            <= '0;
                        run_cnt        <= '0;
                        clause_ready_o <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= LOAD_C;
                    end
                end
                LOAD_C: begin
                    if (clause_ready_o) begin
                        if (clause_valid_i) begin
                            wr_carray_o <= NUM_CLAUSES'(1) << idx;
                            clause_o    <= clause_data_i;
                            if (idx == LAST_IDX) begin
                                clause_ready_o <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end else begin
                        // Last clause write is on the bus now; var states follow.
                        wr_var_states_o <= '1;
                        vars_states_o   <= vs_q;
                        state           <= WR_VS;
                    end
                end
                WR_VS: begin
                    wr_lvl_states_o <= '1;
                    lvl_states_o    <= ls_q;
                    state           <= WR_LS;
                end
                WR_LS: begin
                    start_core_o  <= 1'b1;
                    base_lvl_en_o <= 1'b1;
                    cur_bin_num_o <= cur_bin_q;
                    load_lvl_o    <= load_lvl_q;
                    base_lvl_o    <= base_lvl_q;
                    state         <= START;
                end
                START: begin
                    // done_core_i is deliberately ignored while start_core_o is high.
                    state <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt_inc;
                    if (done_core_i) begin
                        result_sat_o         <= sat_i;
                        result_unsat_o       <= unsat_i;
                        result_bkt_lvl_o     <= bkt_lvl_i;
                        result_vars_states_o <= eng_vars_states_i;
                        result_lvl_states_o  <= eng_lvl_states_i;
                        run_cycles_o         <= run_cnt_inc;
                        done_o               <= 1'b1;
                        busy_o               <= 1'b0;
                        state                <= CAPTURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sat_bin_loader.sv
`timescale 1ns/1ps
module tb_sat_bin_loader;
    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WL  = 16;
    localparam int CW  = 2*NV;
    localparam int VSW = 19*NV;
    localparam int LSW = 11*NL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_load_i = 1'b0;
    logic [WL-1:0] cur_bin_num_i = '0, load_lvl_i = '0, base_lvl_i = '0;
    logic [VSW-1:0] vars_states_i = '0;
    logic [LSW-1:0] lvl_states_i = '0;
    logic clause_valid_i = 1'b0;
    logic clause_ready_o;
    logic [CW-1:0] clause_data_i = '0;
    logic busy_o, done_o, result_sat_o, result_unsat_o;
    logic [WL-1:0] result_bkt_lvl_o;
    logic [VSW-1:0] result_vars_states_o;
    logic [LSW-1:0] result_lvl_states_o;
    logic [31:0] run_cycles_o;
    logic [NC-1:0] wr_carray_o;
    logic [CW-1:0] clause_o;
    logic [NV-1:0] wr_var_states_o;
    logic [VSW-1:0] vars_states_o;
    logic [NL-1:0] wr_lvl_states_o;
    logic [LSW-1:0] lvl_states_o;
    logic start_core_o, base_lvl_en_o;
    logic [WL-1:0] cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic done_core_i = 1'b0, sat_i = 1'b0, unsat_i = 1'b0;
    logic [WL-1:0] bkt_lvl_i = '0;
    logic [VSW-1:0] eng_vars_states_i = '0;
    logic [LSW-1:0] eng_lvl_states_i = '0;

    sat_bin_loader dut (
        .clk(clk), .rst(rst), .start_load_i(start_load_i),
        .cur_bin_num_i(cur_bin_num_i), .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i),
        .vars_states_i(vars_states_i), .lvl_states_i(lvl_states_i),
        .clause_valid_i(clause_valid_i), .clause_ready_o(clause_ready_o), .clause_data_i(clause_data_i),
        .busy_o(busy_o), .done_o(done_o), .result_sat_o(result_sat_o), .result_unsat_o(result_unsat_o),
        .result_bkt_lvl_o(result_bkt_lvl_o), .result_vars_states_o(result_vars_states_o),
        .result_lvl_states_o(result_lvl_states_o), .run_cycles_o(run_cycles_o),
        .wr_carray_o(wr_carray_o), .clause_o(clause_o), .wr_var_states_o(wr_var_states_o),
        .vars_states_o(vars_states_o), .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o),
        .start_core_o(start_core_o), .base_lvl_en_o(base_lvl_en_o), .cur_bin_num_o(cur_bin_num_o),
        .load_lvl_o(load_lvl_o), .base_lvl_o(base_lvl_o), .done_core_i(done_core_i),
        .sat_i(sat_i), .unsat_i(unsat_i), .bkt_lvl_i(bkt_lvl_i),
        .eng_vars_states_i(eng_vars_states_i), .eng_lvl_states_i(eng_lvl_states_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [NC-1:0] oh; logic [CW-1:0] d; } wr_t;
    typedef struct { int c; logic [VSW-1:0] v; } vs_t;
    typedef struct { int c; logic [LSW-1:0] l; } ls_t;
    typedef struct { int c; logic [WL-1:0] cur; logic [WL-1:0] ld; logic [WL-1:0] base; } st_t;
    typedef struct { int c; logic sat; logic unsat; logic [WL-1:0] bkt;
                     logic [VSW-1:0] v; logic [LSW-1:0] l; logic [31:0] rc; } dn_t;

    wr_t q_wr[$];
    vs_t q_vs[$];
    ls_t q_ls[$];
    st_t q_st[$];
    dn_t q_dn[$];

    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 256'(busy_o), 256'(0));
        chk({tag, "_ctl"}, 256'({done_o, clause_ready_o, result_sat_o, result_unsat_o, result_bkt_lvl_o,
                                 run_cycles_o, wr_carray_o, clause_o, wr_var_states_o, wr_lvl_states_o,
                                 start_core_o, base_lvl_en_o, cur_bin_num_o, load_lvl_o, base_lvl_o}), 256'(0));
        chk({tag, "_res_vs"}, 256'(result_vars_states_o), 256'(0));
        chk({tag, "_res_ls"}, 256'(result_lvl_states_o), 256'(0));
        chk({tag, "_vs"}, 256'(vars_states_o), 256'(0));
        chk({tag, "_ls"}, 256'(lvl_states_o), 256'(0));
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes, or when an expected strobe is due.
    wr_t mw; vs_t mv; ls_t ml; st_t ms; dn_t md;
    always @(negedge clk) if (mon_en) begin
        if (wr_carray_o != '0 || (q_wr.size() > 0 && q_wr[0].c == cyc)) begin
            if (q_wr.size() == 0) chk("wr_unexpected", 256'(wr_carray_o), 256'(0));
            else begin
                mw = q_wr.pop_front();
                chk("wr_cycle", 256'(cyc), 256'(mw.c));
                chk("wr_carray", 256'(wr_carray_o), 256'(mw.oh));
                chk("clause_o", 256'(clause_o), 256'(mw.d));
            end
        end
        if (wr_var_states_o != '0 || (q_vs.size() > 0 && q_vs[0].c == cyc)) begin
            if (q_vs.size() == 0) chk("wrvs_unexpected", 256'(wr_var_states_o), 256'(0));
            else begin
                mv = q_vs.pop_front();
                chk("wrvs_cycle", 256'(cyc), 256'(mv.c));
                chk("wrvs_mask", 256'(wr_var_states_o), 256'({NV{1'b1}}));
                chk("vars_states_o", 256'(vars_states_o), 256'(mv.v));
            end
        end
        if (wr_lvl_states_o != '0 || (q_ls.size() > 0 && q_ls[0].c == cyc)) begin
            if (q_ls.size() == 0) chk("wrls_unexpected", 256'(wr_lvl_states_o), 256'(0));
            else begin
                ml = q_ls.pop_front();
                chk("wrls_cycle", 256'(cyc), 256'(ml.c));
                chk("wrls_mask", 256'(wr_lvl_states_o), 256'({NL{1'b1}}));
                chk("lvl_states_o", 256'(lvl_states_o), 256'(ml.l));
            end
        end
        if (start_core_o || (q_st.size() > 0 && q_st[0].c == cyc)) begin
            if (q_st.size() == 0) chk("start_unexpected", 256'(start_core_o), 256'(0));
            else begin
                ms = q_st.pop_front();
                chk("start_cycle", 256'(cyc), 256'(ms.c));
                chk("start_core_o", 256'(start_core_o), 256'(1));
                chk("base_lvl_en_o", 256'(base_lvl_en_o), 256'(1));
                chk("busy_in_start", 256'(busy_o), 256'(1));
                chk("ctl_outs", 256'({cur_bin_num_o, load_lvl_o, base_lvl_o}), 256'({ms.cur, ms.ld, ms.base}));
            end
        end
        if (done_o || (q_dn.size() > 0 && q_dn[0].c == cyc)) begin
            if (q_dn.size() == 0) chk("done_unexpected", 256'(done_o), 256'(0));
            else begin
                md = q_dn.pop_front();
                chk("done_cycle", 256'(cyc), 256'(md.c));
                chk("done_o", 256'(done_o), 256'(1));
                chk("busy_at_done", 256'(busy_o), 256'(0));
                chk("verdict", 256'({result_sat_o, result_unsat_o, result_bkt_lvl_o}), 256'({md.sat, md.unsat, md.bkt}));
                chk("res_vars", 256'(result_vars_states_o), 256'(md.v));
                chk("res_lvls", 256'(result_lvl_states_o), 256'(md.l));
                chk("run_cycles", 256'(run_cycles_o), 256'(md.rc));
            end
        end
    end

    // One bin: expected engine-side events follow directly from the accept cycles of the clause beats.
    task automatic run_bin(input logic [WL-1:0] cur, input logic [WL-1:0] ld, input logic [WL-1:0] base,
                           input int gap_after, input int gap_len, input int run_len,
                           input bit early, input bit ign, input bit mid_rst,
                           input logic sat, input logic unsat, input logic [WL-1:0] bkt);
        logic [CW-1:0]  cl [NC];
        logic [VSW-1:0] vs;
        logic [LSW-1:0] ls;
        logic [255:0]   r;
        int acc, gap_left, L, T;
        wr_t w; vs_t v; ls_t l; st_t s; dn_t d;
        for (int i = 0; i < NC; i++) cl[i] = CW'($urandom());
        r = rnd256(); vs = r[VSW-1:0];
        r = rnd256(); ls = r[LSW-1:0];

        start_load_i = 1'b1;
        cur_bin_num_i = cur; load_lvl_i = ld; base_lvl_i = base;
        vars_states_i = vs; lvl_states_i = ls;
        step();
        start_load_i = 1'b0;
        cur_bin_num_i = WL'($urandom()); load_lvl_i = WL'($urandom()); base_lvl_i = WL'($urandom());
        r = rnd256(); vars_states_i = r[VSW-1:0];
        r = rnd256(); lvl_states_i = r[LSW-1:0];

        acc = 0; gap_left = 0;
        while (acc < NC) begin
            start_load_i = ign && (acc == 2);
            if (gap_left > 0) begin
                clause_valid_i = 1'b0;
                clause_data_i = CW'($urandom());
                gap_left--;
            end else begin
                clause_valid_i = 1'b1;
                clause_data_i = cl[acc];
                w.c = cyc + 1; w.oh = '0; w.oh[acc] = 1'b1; w.d = cl[acc];
                q_wr.push_back(w);
                acc++;
                if (acc == gap_after) gap_left = gap_len;
            end
            step();
        end
        clause_valid_i = 1'b0;
        start_load_i = 1'b0;
        L = cyc - 1;
        v.c = L + 2; v.v = vs;  q_vs.push_back(v);
        l.c = L + 3; l.l = ls;  q_ls.push_back(l);
        s.c = L + 4; s.cur = cur; s.ld = ld; s.base = base; q_st.push_back(s);
        T = early ? L + 5 : L + 4 + run_len;

        while (cyc < T) begin
            done_core_i  = early && (cyc == L + 4);
            start_load_i = ign && (cyc == L + 6);
            if (mid_rst && cyc == L + 8) begin
                mon_en = 1'b0;
                rst = 1'b0;
                #2;
                check_all_zero("midrst");
                q_wr.delete(); q_vs.delete(); q_ls.delete(); q_st.delete(); q_dn.delete();
                step(); step();
                rst = 1'b1;
                step();
                mon_en = 1'b1;
                return;
            end
            step();
        end
        start_load_i = 1'b0;
        done_core_i = 1'b1;
        sat_i = sat; unsat_i = unsat; bkt_lvl_i = bkt;
        r = rnd256(); eng_vars_states_i = r[VSW-1:0];
        r = rnd256(); eng_lvl_states_i = r[LSW-1:0];
        d.c = T + 1; d.sat = sat; d.unsat = unsat; d.bkt = bkt;
        d.v = eng_vars_states_i; d.l = eng_lvl_states_i; d.rc = 32'(T - (L + 4));
        q_dn.push_back(d);
        step();
        done_core_i = 1'b0;
        sat_i = ~sat; unsat_i = ~unsat; bkt_lvl_i = WL'($urandom());
        r = rnd256(); eng_vars_states_i = r[VSW-1:0];
        r = rnd256(); eng_lvl_states_i = r[LSW-1:0];
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        mon_en = 1'b1;

        // Directed: back-to-back stream, controls 1/1/1, unsat with bkt 2 after 20 RUN cycles.
        run_bin(16'd1, 16'd1, 16'd1, 0, 0, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        repeat (2) step();
        // Stalled stream after beat 3, plus starts pulsed while busy.
        run_bin(WL'($urandom()), WL'($urandom()), WL'($urandom()), 3, 3, 10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, WL'($urandom()));
        step();
        // done_core_i already high in the START cycle.
        run_bin(WL'($urandom()), WL'($urandom()), WL'($urandom()), 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, WL'($urandom()));
        // Start in the done_o cycle is accepted.
        run_bin(WL'($urandom()), WL'($urandom()), WL'($urandom()), 5, 1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WL'($urandom()));
        // Reset mid-RUN, then a fresh bin.
        run_bin(WL'($urandom()), WL'($urandom()), WL'($urandom()), 0, 0, 30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int n = 0; n < 8; n++) begin
            run_bin(WL'($urandom()), WL'($urandom()), WL'($urandom()),
                    int'($urandom_range(NC, 1)), int'($urandom_range(4, 0)), int'($urandom_range(15, 1)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0,
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), WL'($urandom()));
            repeat ($urandom_range(2, 0)) step();
        end
        repeat (4) step();
        chk("scoreboard_drained", 256'(q_wr.size() + q_vs.size() + q_ls.size() + q_st.size() + q_dn.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
